// File: rtl/sharpen_pkg.sv
// Shared definitions for the sharpening datapath.
//   PIX_W / DATA_W : pixel width and packed two-pixel word width
//   unpk_state_t   : pixel unpacker state encoding
package sharpen_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned DATA_W = 2 * PIX_W;

  typedef enum logic [1:0] {
    UNPK_IDLE = 2'd0,
    UNPK_LO   = 2'd1,
    UNPK_HI   = 2'd2
  } unpk_state_t;

endpackage

// File: rtl/word_fifo.sv
// Synchronous WIDTH x DEPTH word FIFO with show-ahead read data.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   clear      : synchronous clear; a push or pop in the same cycle is dropped
//   push/wdata : write request and data (caller guarantees !full)
//   pop/rdata  : read request (caller guarantees !empty); rdata is the head word
//   full/empty : derived from count
//   count      : words currently stored
module word_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/pixel_unpack_fifo.sv
// Buffers packed two-pixel words and emits one pixel per cycle, low byte first.
//   CLK, RESET           : rising-edge clock, synchronous active-high reset
//   IN_D/IN_VALID/IN_READY     : word input handshake
//   FLUSH                : synchronous clear of FIFO and unpacker
//   PIX_OUT/PIX_VALID/PIX_READY: pixel output handshake (PIX_OUT registered)
//   WORD_CNT             : words in the FIFO, not counting the unpack register
module pixel_unpack_fifo #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned DATA_W = 2 * PIX_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [DATA_W-1:0]          IN_D,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic                       FLUSH,
  output logic [PIX_W-1:0]           PIX_OUT,
  output logic                       PIX_VALID,
  input  logic                       PIX_READY,
  output logic [$clog2(DEPTH+1)-1:0] WORD_CNT
);

  import sharpen_pkg::*;

  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] hold;
  logic [PIX_W-1:0]  pix;
  unpk_state_t       state;

  // Built from registered FIFO state and FLUSH only, so no path from PIX_READY.
  assign IN_READY = !full && !FLUSH;
  assign push     = IN_VALID && IN_READY;

  word_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .reset (RESET),
    .clear (FLUSH),
    .push  (push),
    .wdata (IN_D),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (WORD_CNT)
  );

  // Refill HOLD from IDLE, or straight from HI when the high byte is taken,
  // so back-to-back words stream without a bubble.
  always_comb begin
    pop = 1'b0;
    if (!FLUSH) begin
      case (state)
        UNPK_IDLE: pop = !empty;
        UNPK_HI:   pop = PIX_READY && !empty;
        default:   pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      state <= UNPK_IDLE;
      hold  <= '0;
      pix   <= '0;
    end else begin
      case (state)
        UNPK_IDLE: begin
          if (pop) begin
            hold  <= head;
            pix   <= head[PIX_W-1:0];
            state <= UNPK_LO;
          end
        end
        UNPK_LO: begin
          if (PIX_READY) begin
            pix   <= hold[DATA_W-1:PIX_W];
            state <= UNPK_HI;
          end
        end
        UNPK_HI: begin
          if (PIX_READY) begin
            if (pop) begin
              hold  <= head;
              pix   <= head[PIX_W-1:0];
              state <= UNPK_LO;
            end else begin
              pix   <= '0;
              state <= UNPK_IDLE;
            end
          end
        end
        default: begin
          pix   <= '0;
          state <= UNPK_IDLE;
        end
      endcase
    end
  end

  assign PIX_OUT   = pix;
  assign PIX_VALID = (state != UNPK_IDLE);

endmodule
